// File: rtl/inst_fetch_pkg.sv
// Shared CPU fetch constants: reset vector, NOP encoding, region nibbles and fetch FSM encoding.
package inst_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT    = 32'h4000_0000;
   localparam logic [3:0]  BIOS_REGION_DEFAULT = 4'h4;
   localparam logic [3:0]  IMEM_REGION_DEFAULT = 4'h1;
   localparam logic [31:0] NOP_INST            = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   // Clears the byte-offset bits so the PC always addresses a whole word.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch stage, its instruction memories and the decode stage.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        bios_ena;
   logic [11:0] bios_addr;
   logic [31:0] bios_dout;
   logic        imem_ena;
   logic [13:0] imem_addr;
   logic [31:0] imem_dout;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;
   logic        if_fault;

   modport master (
      input  stall, redirect, redirect_pc, bios_dout, imem_dout,
      output bios_ena, bios_addr, imem_ena, imem_addr,
      output if_pc, if_inst, if_valid, if_fault
   );

   modport slave (
      output stall, redirect, redirect_pc, bios_dout, imem_dout,
      input  bios_ena, bios_addr, imem_ena, imem_addr,
      input  if_pc, if_inst, if_valid, if_fault
   );
endinterface

// File: rtl/fetch_region_decode.sv
// Combinational region decode of the PC plus the fetched-word mux (NOP + fault outside both regions).
module fetch_region_decode
   import inst_fetch_pkg::*;
#(
   parameter logic [3:0] BIOS_REGION = BIOS_REGION_DEFAULT,
   parameter logic [3:0] IMEM_REGION = IMEM_REGION_DEFAULT
) (
   input  logic [3:0]  region,
   input  logic [13:0] offset,
   input  logic        fetch_en,
   input  logic [31:0] bios_dout,
   input  logic [31:0] imem_dout,
   output logic        bios_ena,
   output logic [11:0] bios_addr,
   output logic        imem_ena,
   output logic [13:0] imem_addr,
   output logic [31:0] word,
   output logic        fault
);

   assign bios_addr = offset[11:0];
   assign imem_addr = offset;

   // Select the memory owning this region and mux its read data.
   always_comb begin
      bios_ena = 1'b0;
      imem_ena = 1'b0;
      word     = NOP_INST;
      fault    = 1'b1;
      if (fetch_en && (region == BIOS_REGION)) begin
         bios_ena = 1'b1;
         word     = bios_dout;
         fault    = 1'b0;
      end else if (fetch_en && (region == IMEM_REGION)) begin
         imem_ena = 1'b1;
         word     = imem_dout;
         fault    = 1'b0;
      end else begin
         word  = NOP_INST;
         fault = 1'b1;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/FLUSH control and the registered fetch output.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter logic [3:0]  BIOS_REGION = BIOS_REGION_DEFAULT,
   parameter logic [3:0]  IMEM_REGION = IMEM_REGION_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   inst_fetch_if.master bus
);

   fetch_state_e state_r, state_s;
   logic [31:0]  pc_q, pc_s;
   logic [31:0]  if_pc_r, if_pc_s;
   logic [31:0]  if_inst_r, if_inst_s;
   logic         if_valid_r, if_valid_s;
   logic         if_fault_r, if_fault_s;
   logic [31:0]  word_s;
   logic         fault_s;

   fetch_region_decode #(
      .BIOS_REGION (BIOS_REGION),
      .IMEM_REGION (IMEM_REGION)
   ) u_decode (
      .region    (pc_q[31:28]),
      .offset    (pc_q[13:0]),
      .fetch_en  (state_r != BOOT),
      .bios_dout (bus.bios_dout),
      .imem_dout (bus.imem_dout),
      .bios_ena  (bus.bios_ena),
      .bios_addr (bus.bios_addr),
      .imem_ena  (bus.imem_ena),
      .imem_addr (bus.imem_addr),
      .word      (word_s),
      .fault     (fault_s)
   );

   assign bus.if_pc    = if_pc_r;
   assign bus.if_inst  = if_inst_r;
   assign bus.if_valid = if_valid_r;
   assign bus.if_fault = if_fault_r;

   // Next-state and next-output logic; redirect outranks stall, BOOT ignores both.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_q;
      if_pc_s    = if_pc_r;
      if_inst_s  = if_inst_r;
      if_valid_s = if_valid_r;
      if_fault_s = if_fault_r;
      case (state_r)
         BOOT: begin
            state_s = RUN;
         end
         RUN, FLUSH: begin
            if (bus.redirect) begin
               pc_s       = word_align(bus.redirect_pc);
               if_inst_s  = NOP_INST;
               if_valid_s = 1'b0;
               if_fault_s = 1'b0;
               state_s    = FLUSH;
            end else if (bus.stall) begin
               state_s = state_r;
            end else begin
               pc_s       = pc_q + 32'd4;
               if_pc_s    = pc_q;
               if_inst_s  = word_s;
               if_valid_s = 1'b1;
               if_fault_s = fault_s;
               state_s    = RUN;
            end
         end
         default: begin
            state_s = BOOT;
         end
      endcase
   end

   // State, PC and fetch output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= BOOT;
         pc_q       <= word_align(RESET_PC);
         if_pc_r    <= 32'h0000_0000;
         if_inst_r  <= NOP_INST;
         if_valid_r <= 1'b0;
         if_fault_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_q       <= pc_s;
         if_pc_r    <= if_pc_s;
         if_inst_r  <= if_inst_s;
         if_valid_r <= if_valid_s;
         if_fault_r <= if_fault_s;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized stall/redirect traffic.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] bios_mem [0:1023];
   logic [31:0] imem_mem [0:4095];
   assign bus.bios_dout = bios_mem[bus.bios_addr[11:2]];
   assign bus.imem_dout = imem_mem[bus.imem_addr[13:2]];

   int passed = 0;
   int total  = 0;

   // Reference model: architectural PC plus what decode should currently see.
   bit          m_boot;
   logic [31:0] m_pc;
   logic [31:0] e_pc;
   logic [31:0] e_inst;
   logic        e_valid;
   logic        e_fault;

   function automatic logic [32:0] ref_fetch(input logic [31:0] a);
      case (a[31:28])
         4'h4:    return {1'b0, bios_mem[a[11:2]]};
         4'h1:    return {1'b0, imem_mem[a[13:2]]};
         default: return {1'b1, 32'h0000_0013};
      endcase
   endfunction

   task automatic model_reset();
      m_boot  = 1'b1;
      m_pc    = 32'h4000_0000;
      e_pc    = 32'h0;
      e_inst  = 32'h0000_0013;
      e_valid = 1'b0;
      e_fault = 1'b0;
   endtask

   task automatic tick();
      logic        r;
      logic        s;
      logic [31:0] t;
      r = bus.redirect;
      s = bus.stall;
      t = bus.redirect_pc;
      @(posedge clk);
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (r) begin
         m_pc    = {t[31:2], 2'b00};
         e_valid = 1'b0;
         e_inst  = 32'h0000_0013;
         e_fault = 1'b0;
      end else if (!s) begin
         {e_fault, e_inst} = ref_fetch(m_pc);
         e_pc    = m_pc;
         e_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      #1;
   endtask

   task automatic test_reset();
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_ena, bus.imem_ena}
          !== {32'h0, 32'h0000_0013, 4'b0000}) begin
         $display("FAIL reset_values: got pc=%h inst=%h v=%b f=%b be=%b ie=%b want 0/00000013/0/0/0/0",
                  bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_ena, bus.imem_ena);
      end else passed++;
      rst = 1'b0;
      #1;
      total++;
      if ({bus.if_valid, bus.bios_ena} !== 2'b00) begin
         $display("FAIL boot_no_fetch: got v=%b be=%b want 0 0", bus.if_valid, bus.bios_ena);
      end else passed++;
   endtask

   task automatic test_boot_sequence();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h1000_0000;
      tick();
      bus.redirect = 1'b0;
      total++;
      if ({bus.if_valid, bus.bios_ena, bus.imem_ena, bus.bios_addr} !== {3'b010, 12'h000}) begin
         $display("FAIL boot_redirect_ignored: got v=%b be=%b ie=%b ba=%h want 0 1 0 000",
                  bus.if_valid, bus.bios_ena, bus.imem_ena, bus.bios_addr);
      end else passed++;
      tick();
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault} !== {32'h4000_0000, 32'hAAAA_0001, 2'b10}) begin
         $display("FAIL first_fetch: got %h/%h v=%b f=%b want 40000000/aaaa0001 v=1 f=0",
                  bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault);
      end else passed++;
      tick();
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_valid} !== {32'h4000_0004, 32'hAAAA_0002, 1'b1}) begin
         $display("FAIL second_fetch: got %h/%h v=%b want 40000004/aaaa0002 v=1",
                  bus.if_pc, bus.if_inst, bus.if_valid);
      end else passed++;
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_addr}
             !== {32'h4000_0004, 32'hAAAA_0002, 2'b10, 12'h008}) begin
            $display("FAIL stall_hold[%0d]: got %h/%h v=%b f=%b ba=%h want 40000004/aaaa0002 1 0 008",
                     i, bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_addr);
         end else passed++;
      end
      bus.stall = 1'b0;
      tick();
      total++;
      if ({bus.if_pc, bus.if_inst, bus.bios_addr} !== {32'h4000_0008, bios_mem[2], 12'h00C}) begin
         $display("FAIL stall_resume: got %h/%h ba=%h want 40000008/%h ba=00c",
                  bus.if_pc, bus.if_inst, bus.bios_addr, bios_mem[2]);
      end else passed++;
   endtask

   task automatic test_redirect_over_stall();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h1000_0002;
      bus.stall       = 1'b1;
      tick();
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;
      total++;
      if ({bus.if_valid, bus.if_fault, bus.imem_ena, bus.imem_addr, bus.if_inst}
          !== {3'b001, 14'h0000, 32'h0000_0013}) begin
         $display("FAIL redirect_flush: got v=%b f=%b ie=%b ia=%h inst=%h want 0 0 1 0000 00000013",
                  bus.if_valid, bus.if_fault, bus.imem_ena, bus.imem_addr, bus.if_inst);
      end else passed++;
      tick();
      total++;
      if ({bus.if_valid, bus.if_pc, bus.if_inst} !== {1'b1, 32'h1000_0000, imem_mem[0]}) begin
         $display("FAIL redirect_target: got v=%b %h/%h want 1 10000000/%h",
                  bus.if_valid, bus.if_pc, bus.if_inst, imem_mem[0]);
      end else passed++;
   endtask

   task automatic test_fault_region();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h8000_0000;
      tick();
      bus.redirect = 1'b0;
      tick();
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_fault, bus.if_valid, bus.bios_ena, bus.imem_ena}
          !== {32'h8000_0000, 32'h0000_0013, 4'b1100}) begin
         $display("FAIL fault_region: got %h/%h f=%b v=%b be=%b ie=%b want 80000000/00000013 1 1 0 0",
                  bus.if_pc, bus.if_inst, bus.if_fault, bus.if_valid, bus.bios_ena, bus.imem_ena);
      end else passed++;
   endtask

   task automatic test_wrap();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      tick();
      bus.redirect = 1'b0;
      tick();
      total++;
      if ({bus.if_pc, bus.if_fault} !== {32'hFFFF_FFFC, 1'b1}) begin
         $display("FAIL wrap_last: got %h f=%b want fffffffc 1", bus.if_pc, bus.if_fault);
      end else passed++;
      tick();
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault} !== {32'h0, 32'h0000_0013, 2'b11}) begin
         $display("FAIL wrap_zero: got %h/%h v=%b f=%b want 00000000/00000013 1 1",
                  bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault);
      end else passed++;
      total++;
      if ((^{bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_ena, bus.bios_addr,
             bus.imem_ena, bus.imem_addr}) === 1'bx) begin
         $display("FAIL wrap_no_x: got X on outputs want none");
      end else passed++;
   endtask

   task automatic test_random();
      logic [31:0] rnd;
      logic        exp_be;
      logic        exp_ie;
      for (int i = 0; i < 300; i++) begin
         rnd = $urandom();
         bus.stall    = ($urandom_range(0, 3) == 0);
         bus.redirect = ($urandom_range(0, 6) == 0);
         case ($urandom_range(0, 2))
            0:       bus.redirect_pc = {4'h4, 16'h0000, rnd[11:0]};
            1:       bus.redirect_pc = {4'h1, 14'h0000, rnd[13:0]};
            default: bus.redirect_pc = rnd;
         endcase
         tick();
         total++;
         if ({bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault} !== {e_pc, e_inst, e_valid, e_fault}) begin
            $display("FAIL random_out[%0d]: got %h/%h v=%b f=%b want %h/%h v=%b f=%b", i,
                     bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, e_pc, e_inst, e_valid, e_fault);
         end else passed++;
         exp_be = !m_boot && (m_pc[31:28] == 4'h4);
         exp_ie = !m_boot && (m_pc[31:28] == 4'h1);
         total++;
         if ({bus.bios_ena, bus.imem_ena, bus.bios_addr, bus.imem_addr}
             !== {exp_be, exp_ie, m_pc[11:0], m_pc[13:0]}) begin
            $display("FAIL random_mem[%0d]: got be=%b ie=%b ba=%h ia=%h want be=%b ie=%b ba=%h ia=%h", i,
                     bus.bios_ena, bus.imem_ena, bus.bios_addr, bus.imem_addr,
                     exp_be, exp_ie, m_pc[11:0], m_pc[13:0]);
         end else passed++;
      end
      bus.stall    = 1'b0;
      bus.redirect = 1'b0;
   endtask

   task automatic test_async_reset();
      tick();
      tick();
      bus.stall = 1'b1;
      tick();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_ena, bus.imem_ena}
          !== {32'h0, 32'h0000_0013, 4'b0000}) begin
         $display("FAIL async_reset: got pc=%h inst=%h v=%b f=%b be=%b ie=%b want 0/00000013/0/0/0/0",
                  bus.if_pc, bus.if_inst, bus.if_valid, bus.if_fault, bus.bios_ena, bus.imem_ena);
      end else passed++;
      model_reset();
      bus.stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      total++;
      if (bus.if_valid !== 1'b0) begin
         $display("FAIL restart_boot: got v=%b want 0", bus.if_valid);
      end else passed++;
      tick();
      total++;
      if ({bus.if_pc, bus.if_inst, bus.if_valid} !== {32'h4000_0000, 32'hAAAA_0001, 1'b1}) begin
         $display("FAIL restart_first: got %h/%h v=%b want 40000000/aaaa0001 1",
                  bus.if_pc, bus.if_inst, bus.if_valid);
      end else passed++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) bios_mem[i] = $urandom();
      for (int i = 0; i < 4096; i++) imem_mem[i] = $urandom();
      bios_mem[0] = 32'hAAAA_0001;
      bios_mem[1] = 32'hAAAA_0002;
      test_reset();
      test_boot_sequence();
      test_stall();
      test_redirect_over_stall();
      test_fault_region();
      test_wrap();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
